// File: rtl/instr_encoder.sv
// Symbolic MIPS instruction encoder and sequential instruction-memory loader.
// state | meaning: IDLE wait for start_i; RUN accept/encode requests; DONE one-cycle end pulse
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_kind_i,
  input  logic [4:0]        req_rs_i,
  input  logic [4:0]        req_rt_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_shamt_i,
  input  logic [5:0]        req_funct_i,
  input  logic [15:0]       req_imm_i,
  input  logic              req_last_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W:0]   LIMIT   = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q;
  logic            full, fire, legal, fills, end_sess;
  logic [31:0]     enc_word;

  always_comb begin
    enc_word = 32'd0;
    case (req_kind_i)
      3'd0: enc_word = {6'b000000, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i};
      3'd1: enc_word = {6'b001000, req_rs_i, req_rt_i, req_imm_i};
      3'd2: enc_word = {6'b001011, req_rs_i, req_rt_i, req_imm_i};
      3'd3: enc_word = {6'b000100, req_rs_i, req_rt_i, req_imm_i};
      3'd4: enc_word = {6'b001111, 5'd0, req_rt_i, req_imm_i};
      3'd5: enc_word = {6'b001101, req_rs_i, req_rt_i, req_imm_i};
      3'd6: enc_word = {6'b000101, req_rs_i, req_rt_i, req_imm_i};
      default: enc_word = 32'd0;
    endcase
  end

  always_comb begin
    full        = (count_q == LIMIT);
    req_ready_o = (state_q == S_RUN) && !full;
    fire        = req_valid_i && req_ready_o;
    legal       = (req_kind_i != 3'd7);
    // the write that fills the final word closes the session on its own
    fills       = legal && ((count_q + CNT_ONE) == LIMIT);
    end_sess    = fire && (req_last_i || fills);
    state_d     = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (end_sess) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= BASE;
      mem_data_o <= 32'd0;
      err_o      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_o <= fire && legal;
      if (state_q == S_IDLE && start_i) begin
        count_q <= '0;
        err_o   <= 1'b0;
      end
      if (fire) begin
        if (legal) begin
          mem_addr_o <= BASE + count_q[ADDR_W-1:0];
          mem_data_o <= enc_word;
          count_q    <= count_q + CNT_ONE;
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: an ADDR_W=8 instance and a small ADDR_W=2 instance.
module tb_instr_encoder;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [8:0]  cnt;
    logic        done;
  } exp_t;

  logic clk = 0;
  logic rst, start_a, start_b, req_valid, req_last;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;

  logic        rdy_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  cnt_a;
  logic        rdy_b, we_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  cnt_b;

  int tests = 0, errors = 0;
  exp_t q_a[$], q_b[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .req_valid_i(req_valid), .req_ready_o(rdy_a),
    .req_kind_i(req_kind), .req_rs_i(req_rs), .req_rt_i(req_rt), .req_rd_i(req_rd),
    .req_shamt_i(req_shamt), .req_funct_i(req_funct), .req_imm_i(req_imm), .req_last_i(req_last),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_data_o(data_a), .busy_o(busy_a),
    .done_o(done_a), .err_o(err_a), .count_o(cnt_a));

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .req_valid_i(req_valid), .req_ready_o(rdy_b),
    .req_kind_i(req_kind), .req_rs_i(req_rs), .req_rt_i(req_rt), .req_rd_i(req_rd),
    .req_shamt_i(req_shamt), .req_funct_i(req_funct), .req_imm_i(req_imm), .req_last_i(req_last),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_data_o(data_b), .busy_o(busy_b),
    .done_o(done_b), .err_o(err_b), .count_o(cnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we_a) begin
      if (q_a.size() == 0) begin
        tests++; errors++;
        $display("FAIL a_unexpected_write: addr 0x%02h data 0x%08h, expected no write", addr_a, data_a);
      end else begin
        e = q_a.pop_front();
        chk("a_addr", {24'd0, addr_a}, {24'd0, e.addr});
        chk("a_data", data_a, e.data);
        chk("a_count", {23'd0, cnt_a}, {23'd0, e.cnt});
        chk("a_done", {31'd0, done_a}, {31'd0, e.done});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (we_b) begin
      if (q_b.size() == 0) begin
        tests++; errors++;
        $display("FAIL b_unexpected_write: addr 0x%01h data 0x%08h, expected no write", addr_b, data_b);
      end else begin
        e = q_b.pop_front();
        chk("b_addr", {30'd0, addr_b}, {24'd0, e.addr});
        chk("b_data", data_b, e.data);
        chk("b_count", {29'd0, cnt_b}, {23'd0, e.cnt});
        chk("b_done", {31'd0, done_b}, {31'd0, e.done});
      end
    end
  end

  // Presents one request, waits (bounded) for acceptance, and queues the expected write.
  task automatic issue(input int which, input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic last, input logic push,
                       input logic [31:0] edata, input int eaddr, input int ecnt, input logic edone);
    exp_t e;
    bit fired = 0;
    req_kind = kind; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_funct = fn; req_imm = imm; req_last = last; req_valid = 1'b1;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clk);
      if ((which == 0) ? rdy_a : rdy_b) begin
        fired = 1;
        if (push) begin
          e.addr = 8'(eaddr); e.data = edata; e.cnt = 9'(ecnt); e.done = edone;
          if (which == 0) q_a.push_back(e); else q_b.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_last = 1'b0;
    if (!fired) begin
      tests++; errors++;
      $display("FAIL issue_timeout: dut %0d never ready, expected acceptance", which);
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start_a = 0; start_b = 0; req_valid = 0; req_last = 0; req_kind = 0;
    req_rs = 0; req_rt = 0; req_rd = 0; req_shamt = 0; req_funct = 0; req_imm = 0;
    idle(3);
    chk("rst_ready", {31'd0, rdy_a}, 0);
    chk("rst_we", {31'd0, we_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_err", {31'd0, err_a}, 0);
    chk("rst_addr", {24'd0, addr_a}, 0);
    chk("rst_data", data_a, 0);
    chk("rst_count", {23'd0, cnt_a}, 0);
    rst = 0;
    idle(2);

    // single ADDI with last
    pulse_start(0);
    chk("start_busy", {31'd0, busy_a}, 1);
    issue(0, 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 1, 1, 32'h20220005, 0, 1, 1);
    idle(2);
    chk("t1_busy_after", {31'd0, busy_a}, 0);
    chk("t1_ready_after", {31'd0, rdy_a}, 0);
    chk("t1_count", {23'd0, cnt_a}, 1);

    // back-to-back stream
    pulse_start(0);
    issue(0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 0, 1, 32'h00221820, 0, 1, 0);
    issue(0, 3'd4, 5'd7, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 0, 1, 32'h3C041234, 1, 2, 0);
    issue(0, 3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 0, 1, 32'h1022FFFF, 2, 3, 0);
    issue(0, 3'd6, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1, 1, 32'h1422FFFF, 3, 4, 1);
    idle(2);
    chk("t2_count", {23'd0, cnt_a}, 4);

    // illegal kind between two legal requests
    pulse_start(0);
    issue(0, 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 0, 1, 32'h20220005, 0, 1, 0);
    issue(0, 3'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 0, 0, 32'd0, 0, 0, 0);
    chk("t3_err_set", {31'd0, err_a}, 1);
    issue(0, 3'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 1, 1, 32'h346400FF, 1, 2, 1);
    idle(3);
    chk("t3_err_sticky", {31'd0, err_a}, 1);
    chk("t3_count", {23'd0, cnt_a}, 2);
    pulse_start(0);
    chk("t3_err_clear", {31'd0, err_a}, 0);
    issue(0, 3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 1, 0, 32'd0, 0, 0, 0);
    idle(2);
    chk("t3_illegal_last_idle", {31'd0, busy_a}, 0);
    chk("t3_err_again", {31'd0, err_a}, 1);

    // capacity limit on the 4-word instance
    pulse_start(1);
    for (int k = 0; k < 4; k++)
      issue(1, 3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(k), 0, 1, 32'h20010000 + k, k, k + 1, k == 3);
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_ready_low", {31'd0, rdy_b}, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_count", {29'd0, cnt_b}, 4);
    chk("t4_idle", {31'd0, busy_b}, 0);

    // reset right after a fire
    pulse_start(0);
    issue(0, 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0009, 0, 0, 32'd0, 0, 0, 0);
    rst = 1; #1;
    chk("t5_we", {31'd0, we_a}, 0);
    chk("t5_count", {23'd0, cnt_a}, 0);
    chk("t5_idle", {31'd0, busy_a}, 0);
    idle(2);
    rst = 0;
    idle(4);
    chk("t5_we_after", {31'd0, we_a}, 0);

    // valid in IDLE, start during RUN
    req_valid = 1'b1; req_kind = 3'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_idle_ready", {31'd0, rdy_a}, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    pulse_start(0);
    issue(0, 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 0, 1, 32'h20220005, 0, 1, 0);
    pulse_start(0);
    issue(0, 3'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 1, 1, 32'h346400FF, 1, 2, 1);
    idle(3);
    chk("t6_count", {23'd0, cnt_a}, 2);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader: the inverse of the control decoder. It accepts symbolic instruction requests (kind, register fields, immediate) over a valid/ready handshake. Each request is packed into a 32-bit instruction word using the same opcode map the decoder consumes, then written to consecutive instruction-memory words. Used by the test harness and boot path to fill instruction memory before the CPU is released from reset.

## Interface

- ADDR_W, 8, word-address width of the instruction-memory write port; capacity DEPTH = 2**ADDR_W words
- BASE_ADDR, 0, first word address written after start_i
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin a load session; honoured only in IDLE
- req_valid_i  in  1  request present
- req_ready_o  out  1  encoder can accept this cycle
- req_kind_i  in  3  0 R_TYPE, 1 ADDI, 2 SLTIU, 3 BEQ, 4 LUI, 5 ORI, 6 BNE, 7 illegal
- req_rs_i / req_rt_i / req_rd_i / req_shamt_i  in  5 each  register/shift fields
- req_funct_i  in  6  R-type funct
- req_imm_i  in  16  immediate / branch offset
- req_last_i  in  1  this request ends the session
- mem_we_o  out  1  instruction-memory write strobe
- mem_addr_o  out  ADDR_W  word address
- mem_data_o  out  32  encoded instruction
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at session end
- err_o  out  1  sticky illegal-kind flag, cleared by accepted start_i
- count_o  out  ADDR_W+1  words written this session

## Operation

- States: IDLE, RUN, DONE.
- IDLE → RUN on start_i. Clears the write pointer to BASE_ADDR, count_o to 0, and err_o.
- RUN:
  - req_ready_o = 1 unless the full condition holds; fire = req_valid_i & req_ready_o.
  - On a legal fire, the encoded word and pointer are registered. mem_we_o, mem_addr_o and mem_data_o are driven the next cycle; the pointer and count_o increment by 1.
  - On an illegal fire (kind 7), the request is consumed: no write, no pointer advance, err_o set.
- Encoding:
  - R_TYPE: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm} with op ADDI 001000, SLTIU 001011, BEQ 000100, LUI 001111, ORI 001101, BNE 000101.
  - LUI forces the rs field to 0. shamt/funct/rd are ignored for I-type.
- Full: count reaches DEPTH − BASE_ADDR. The fire that fills the last word behaves as if req_last_i = 1. Pointer never wraps.
- Termination:
  - A fire with req_last_i (legal or illegal) moves RUN → DONE.
  - DONE lasts one cycle, asserts done_o, then → IDLE.
- start_i outside IDLE is ignored. req_valid_i outside RUN is ignored (ready low).

## Timing

- Reset values: state IDLE; req_ready_o, mem_we_o, done_o, busy_o, err_o = 0; mem_addr_o = BASE_ADDR; mem_data_o = 0; count_o = 0.
- Reset mid-session cancels any pending write immediately (asynchronous), with no partial write after release.
- Latency: fire in cycle N → mem_we_o high in cycle N+1 for exactly one cycle.
- Throughput: one write per cycle under back-to-back valid.
- Last fire in cycle N: final write in N+1 (if legal); state DONE in N+1; done_o high in N+1 only; IDLE and ready low from N+2.
- count_o updates in the same cycle mem_we_o asserts.
- busy_o is high from the cycle after start_i through the DONE cycle.

## Test plan

- Reset then start_i, then a single ADDI rs=1 rt=2 imm=0x0005 last=1. Required: one write, addr 0, data 0x20220005; done_o pulses the same cycle; count_o = 1.
- Back-to-back stream of R_TYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20, then LUI rs=7 rt=4 imm=0x1234, then BEQ rs=1 rt=2 imm=0xFFFF, then BNE same fields with last. Required: data 0x00221820, 0x3C041234, 0x1022FFFF, 0x1422FFFF at addrs 0..3 on consecutive cycles.
- Kind 7 inserted between two legal requests. Required: the two legal words land at addrs 0 and 1; err_o goes high and stays high until the next start_i.
- ADDR_W=2 with 6 valid requests and no last. Required: exactly 4 writes at addrs 0..3; done_o after the 4th; req_ready_o low afterwards; count_o = 4.
- rst_i asserted the cycle after a fire. Required: mem_we_o stays 0, count_o = 0, state IDLE, and no write occurs after release.
- start_i pulsed during RUN and req_valid_i held in IDLE. Required: no pointer reset, no writes, req_ready_o = 0 in IDLE.
